imem_loader: RTL and testbench

- Boot-time stage directly upstream of the single-cycle processor.
- Accepts a byte stream carrying a program image (length header, payload, XOR checksum).
- Assembles big-endian 32-bit words and writes them into the instruction memory.
- Holds the processor in reset until the image is verified, then releases it.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/imem_loader_if.sv | 28 ++
 rtl/byte_word_packer.sv | 50 +++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   loader_state_t    : loader FSM state encoding (also exported for debug)
//   LEN_HDR_BYTES     : bytes in the big-endian length header
//   WORD_BYTES        : bytes per instruction word
//   MEM_BYTES_DEFAULT : default instruction memory size / maximum image length
//   len_ok()          : image-length legality rule
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_HI  = 3'd1,
        ST_HDR_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CKSUM   = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } loader_state_t;

    localparam int LEN_HDR_BYTES     = 2;
    localparam int WORD_BYTES        = 4;
    localparam int MEM_BYTES_DEFAULT = 1024;

    // A legal image is non-empty, a whole number of words and fits in memory.
    function automatic logic len_ok(input logic [15:0] len, input int mem_bytes);
        return (len != 16'd0) && (len[1:0] == 2'b00) &&
               ({16'd0, len} <= 32'(mem_bytes));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
//   in_valid/in_data/in_ready : byte stream into the loader
//   mem_we/mem_addr/mem_wdata : word writes out of the loader
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. The source holds in_data stable while in_valid is
// high and not yet accepted; in_ready does not depend on in_valid. in_data is
// don't-care whenever in_ready is low.
// Modports: slave = loader side, master = stream source / memory observer.
interface imem_loader_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into big-endian 32-bit words.
//   clk, reset : clock, async active-high reset
//   clear      : restart word assembly (byte index and partial word to zero)
//   shift_en   : byte_in is accepted this cycle
//   byte_in    : incoming byte
//   word_done  : combinational, this cycle's byte completes a word
//   word       : last completed word (first byte in [31:24])
//   word_valid : one-cycle pulse, the cycle after word_done
module byte_word_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [23:0] partial;
    logic [1:0]  idx;

    assign word_done = shift_en && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            partial    <= '0;
            idx        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_done && !clear;
            if (clear) begin
                partial <= '0;
                idx     <= '0;
            end else if (shift_en) begin
                partial <= {partial[15:0], byte_in};
                idx     <= idx + 2'd1;
                if (idx == LAST_IDX) begin
                    word <= {partial, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a program image (16-bit big-endian length, payload,
// XOR checksum of the payload bytes), writes the payload as big-endian words
// into instruction memory, and holds the processor in reset until the image
// checks out.
//   clk, reset : clock, async active-high reset
//   start      : one-cycle pulse, begins a load from IDLE, RUN or ERROR
//   bus        : byte stream in, memory write strobe/address/data out
//   cpu_reset  : processor reset, low only in RUN
//   done       : high in RUN
//   error      : high in ERROR
//   dbg_state  : current FSM state
module imem_loader
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int ADDR_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output loader_state_t dbg_state
);

    loader_state_t state, next_state;

    logic [15:0] length;
    logic [15:0] count;
    logic [7:0]  cksum;
    logic [15:0] addr_q;
    logic [15:0] hdr_len;
    logic        in_ready;
    logic        accept;
    logic        clear;
    logic        shift_en;
    logic        word_done;
    logic [31:0] word;
    logic        word_valid;

    assign accept   = bus.in_valid && in_ready;
    assign shift_en = accept && (state == ST_PAYLOAD);
    assign hdr_len  = {length[15:8], bus.in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_HDR_HI;
                    clear      = 1'b1;
                end
            end
            ST_HDR_HI: begin
                in_ready = 1'b1;
                if (accept) next_state = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    next_state = len_ok(hdr_len, MEM_BYTES) ? ST_PAYLOAD : ST_ERROR;
                end
            end
            ST_PAYLOAD: begin
                in_ready = 1'b1;
                if (accept && (count == length - 16'd1)) next_state = ST_CKSUM;
            end
            ST_CKSUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    next_state = (bus.in_data == cksum) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) begin
                    next_state = ST_HDR_HI;
                    clear      = 1'b1;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) begin
                    next_state = ST_HDR_HI;
                    clear      = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Length, byte counter, running checksum and write address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            length <= '0;
            count  <= '0;
            cksum  <= '0;
            addr_q <= '0;
        end else begin
            if (clear) begin
                count <= '0;
                cksum <= '0;
            end
            if (accept && state == ST_HDR_HI) length[15:8] <= bus.in_data;
            if (accept && state == ST_HDR_LO) length[7:0]  <= bus.in_data;
            if (shift_en) begin
                count <= count + 16'd1;
                cksum <= cksum ^ bus.in_data;
                // count holds the index of the word's last byte here, so its
                // word-aligned value is the word's starting byte address.
                if (word_done) addr_q <= {count[15:2], 2'b00};
            end
        end
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .shift_en   (shift_en),
        .byte_in    (bus.in_data),
        .word_done  (word_done),
        .word       (word),
        .word_valid (word_valid)
    );

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = word_valid;
    assign bus.mem_wdata = word;
    assign bus.mem_addr  = {{(ADDR_W-16){1'b0}}, addr_q};
    assign dbg_state     = state;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import mips_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 1024;

    typedef logic [7:0] bq_t[$];

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cpu_reset;
    logic          done;
    logic          error;
    loader_state_t dbg_state;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard ----------------
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] sb_e;
    bit                 exp_run;
    logic               prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                sb_e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== sb_e) begin
                    n_fail++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, sb_e[ADDR_W+31:32], sb_e[31:0]);
                end
            end
            n_checks++;
            if (prev_we === 1'b1) begin
                n_fail++;
                $display("FAIL mem_we_back_to_back: mem_we high 2 cycles, required single pulse");
            end
        end
        prev_we = bus.mem_we;
    end

    // ---------------- reference model ----------------
    // Expected writes and outcome from the image rules: 16-bit length header,
    // legal length is nonzero, multiple of 4, <= MEM_BYTES; word k is bytes
    // 4k..4k+3 of the payload at byte address 4k; checksum is the XOR of the
    // payload bytes.
    task automatic model_image(input bq_t img);
        int         len;
        logic [7:0] x;
        len     = int'(img[0]) * 256 + int'(img[1]);
        exp_run = 1'b0;
        if (len == 0 || (len % 4) != 0 || len > MEM_BYTES) return;
        for (int w = 0; w < len / 4; w++) begin
            exp_q.push_back({32'(4 * w), img[LEN_HDR_BYTES + 4*w], img[LEN_HDR_BYTES + 4*w + 1],
                             img[LEN_HDR_BYTES + 4*w + 2], img[LEN_HDR_BYTES + 4*w + 3]});
        end
        x = 8'h00;
        for (int i = 0; i < len; i++) x ^= img[LEN_HDR_BYTES + i];
        exp_run = (img[LEN_HDR_BYTES + len] == x);
    endtask

    function automatic bq_t make_image(input int len, input bit bad_cks);
        bq_t        q;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        q.push_back(8'(len >> 8));
        q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x ^= b;
        end
        if (bad_cks) x ^= 8'($urandom_range(1, 255));
        q.push_back(x);
        return q;
    endfunction

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit s);
        int n;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: in_ready=%b, required 1 within 20 cycles", bus.in_ready);
        end
        start = s;
        @(posedge clk); #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // gap_mode: 0 = back to back, 1 = one idle cycle per byte, 2 = random idles
    task automatic drive_image(input bq_t img, input int gap_mode, input bit rand_start);
        int gap;
        bit s;
        for (int i = 0; i < img.size(); i++) begin
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            s   = rand_start && ($urandom_range(0, 3) == 0);
            send_byte(img[i], gap, s);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        n_checks++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done=%b error=%b want 0 0", done, error); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        reset = 1'b0;
        // Bytes offered in IDLE must be refused and cause nothing.
        bus.in_valid = 1'b1;
        repeat (4) begin
            bus.in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL idle_state: got %0d want IDLE", dbg_state); end
    endtask

    // Payload 20 08 00 05 AC 08 00 00 XORs to 0x89.
    function automatic bq_t basic_image();
        bq_t q;
        q = {8'h00, 8'h08, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
        return q;
    endfunction

    task automatic test_basic(input int gap_mode, input string name);
        bq_t img;
        img = basic_image();
        model_image(img);
        pulse_start();
        drive_image(img, gap_mode, 1'b0);
        settle();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_writes: %0d missing, want 0", name, exp_q.size()); exp_q.delete(); end
        n_checks++; if (done !== exp_run) begin n_fail++; $display("FAIL %s_done: got %b want %b", name, done, exp_run); end
        n_checks++; if (error !== !exp_run) begin n_fail++; $display("FAIL %s_error: got %b want %b", name, error, !exp_run); end
        n_checks++; if (cpu_reset !== !exp_run) begin n_fail++; $display("FAIL %s_cpu_reset: got %b want %b", name, cpu_reset, !exp_run); end
    endtask

    task automatic test_bad_headers();
        logic [15:0] lens[3];
        bq_t         img;
        lens = '{16'h0006, 16'h0404, 16'h0000};
        for (int k = 0; k < 3; k++) begin
            img = {lens[k][15:8], lens[k][7:0]};
            model_image(img);
            pulse_start();
            drive_image(img, 0, 1'b0);
            // Further bytes offered in ERROR must be ignored.
            bus.in_valid = 1'b1;
            repeat (3) begin
                bus.in_data = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            n_checks++; if (error !== !exp_run) begin n_fail++; $display("FAIL bad_hdr_%h_error: got %b want %b", lens[k], error, !exp_run); end
            n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL bad_hdr_%h_cpu_reset: got %b want 1", lens[k], cpu_reset); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bad_hdr_%h_in_ready: got %b want 0", lens[k], bus.in_ready); end
        end
    endtask

    task automatic test_bad_checksum();
        bq_t img;
        img = basic_image();
        img[10] = 8'h00;
        model_image(img);
        pulse_start();
        drive_image(img, 0, 1'b0);
        settle();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bad_cks_writes: %0d missing, want 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (error !== !exp_run) begin n_fail++; $display("FAIL bad_cks_error: got %b want %b", error, !exp_run); end
        n_checks++; if (done !== exp_run) begin n_fail++; $display("FAIL bad_cks_done: got %b want %b", done, exp_run); end
    endtask

    task automatic test_reset_mid_load();
        bq_t img;
        img = basic_image();
        exp_q.push_back({32'h0, 32'h20080005});
        pulse_start();
        for (int i = 0; i < LEN_HDR_BYTES + 5; i++) send_byte(img[i], 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: cpu_reset=%b done=%b error=%b want 1 0 0", cpu_reset, done, error); end
        n_checks++; if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bus: in_ready=%b mem_we=%b want 0 0", bus.in_ready, bus.mem_we); end
        n_checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_mem: addr=%h data=%h want 0 0", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_reset_state: got %0d want IDLE", dbg_state); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_reset_first_word: %0d missing, want 0", exp_q.size()); exp_q.delete(); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_image(img);
        pulse_start();
        drive_image(img, 0, 1'b0);
        settle();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL after_reset_writes: %0d missing, want 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (done !== exp_run) begin n_fail++; $display("FAIL after_reset_done: got %b want %b", done, exp_run); end
    endtask

    task automatic test_restart_from_run();
        bq_t img;
        img = {8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08};
        pulse_start();
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL restart_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b want 0", done); end
        n_checks++; if (dbg_state !== ST_HDR_HI) begin n_fail++; $display("FAIL restart_state: got %0d want HDR_HI", dbg_state); end
        model_image(img);
        drive_image(img, 0, 1'b0);
        settle();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_writes: %0d missing, want 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (done !== exp_run) begin n_fail++; $display("FAIL restart_done_end: got %b want %b", done, exp_run); end
        n_checks++; if (cpu_reset !== !exp_run) begin n_fail++; $display("FAIL restart_cpu_reset_end: got %b want %b", cpu_reset, !exp_run); end
    endtask

    task automatic test_max_length();
        bq_t img;
        img = make_image(MEM_BYTES, 1'b0);
        model_image(img);
        pulse_start();
        drive_image(img, 0, 1'b0);
        settle();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL max_len_writes: %0d missing, want 0", exp_q.size()); exp_q.delete(); end
        n_checks++; if (done !== exp_run) begin n_fail++; $display("FAIL max_len_done: got %b want %b", done, exp_run); end
    endtask

    task automatic test_random();
        bq_t img;
        int  len;
        for (int it = 0; it < 12; it++) begin
            len = 4 * int'($urandom_range(1, 16));
            img = make_image(len, $urandom_range(0, 3) == 0);
            model_image(img);
            pulse_start();
            drive_image(img, 2, 1'b1);
            settle();
            n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand%0d_writes: %0d missing, want 0", it, exp_q.size()); exp_q.delete(); end
            n_checks++; if (done !== exp_run) begin n_fail++; $display("FAIL rand%0d_done: got %b want %b", it, done, exp_run); end
            n_checks++; if (error !== !exp_run) begin n_fail++; $display("FAIL rand%0d_error: got %b want %b", it, error, !exp_run); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "gaps");
        test_bad_headers();
        test_bad_checksum();
        test_reset_mid_load();
        test_restart_from_run();
        test_max_length();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
